// File: rtl/router_1xn_if.sv
// Packet-source and per-port read bundle for router_1xn.
// master drives the packet stream and read requests; slave is the router side.
interface router_1xn_if #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8
);
  logic                            pkt_valid;
  logic [DATA_WIDTH-1:0]           data_in;
  logic                            busy;
  logic                            err;
  logic                            bad_addr;
  logic [NUM_PORTS-1:0]            read_enb;
  logic [NUM_PORTS-1:0]            vld_out;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_out;

  modport master (
    output pkt_valid, data_in, read_enb,
    input  busy, err, bad_addr, vld_out, data_out
  );

  modport slave (
    input  pkt_valid, data_in, read_enb,
    output busy, err, bad_addr, vld_out, data_out
  );
endinterface

// File: rtl/router_1xn.sv
// 1xN packet router: header decode FSM, per-port FIFOs with registered read
// data, parity/length checking and per-port unread-timeout flush.
module router_1xn #(
  parameter int NUM_PORTS  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input logic        clock,
  input logic        resetn,
  router_1xn_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = DATA_WIDTH - 2;
  localparam int CW = DATA_WIDTH - 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {DECODE, LOAD, CHECK, DROP} state_t;

  state_t                  state;
  logic [1:0]              addr_q;
  logic [DATA_WIDTH-1:0]   xor_q;
  logic [LW-1:0]           len_q;
  logic [CW-1:0]           cnt_q;
  logic                    err_q;
  logic                    bad_addr_q;

  logic [AW:0]             wr_ptr [NUM_PORTS];
  logic [AW:0]             rd_ptr [NUM_PORTS];
  logic [TW-1:0]           tmr    [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   mem    [NUM_PORTS][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   dout   [NUM_PORTS];

  logic [NUM_PORTS-1:0]    empty, full, flush, we, re;
  logic [1:0]              hdr_addr;
  logic                    hdr_ok, hdr_empty, cur_full, cur_flush, busy;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dout_flat;

  always_comb begin
    hdr_addr  = bus.data_in[1:0];
    hdr_ok    = int'(hdr_addr) < NUM_PORTS;
    hdr_empty = 1'b0;
    cur_full  = 1'b0;
    cur_flush = 1'b0;
    dout_flat = '0;
    for (int unsigned n = 0; n < NUM_PORTS; n++) begin
      empty[n] = wr_ptr[n] == rd_ptr[n];
      full[n]  = (wr_ptr[n][AW] != rd_ptr[n][AW]) &&
                 (wr_ptr[n][AW-1:0] == rd_ptr[n][AW-1:0]);
      flush[n] = !empty[n] && !bus.read_enb[n] && (tmr[n] == TMAX);
      re[n]    = bus.read_enb[n] && !empty[n];
      // Port index compared in a loop so an unused address never indexes out of range.
      if (hdr_addr == 2'(n)) hdr_empty = empty[n];
      if (addr_q == 2'(n)) begin
        cur_full  = full[n];
        cur_flush = flush[n];
      end
      dout_flat[n*DATA_WIDTH +: DATA_WIDTH] = dout[n];
    end

    case (state)
      DECODE:  busy = bus.pkt_valid && hdr_ok && !hdr_empty;
      LOAD:    busy = cur_full;
      CHECK:   busy = 1'b1;
      default: busy = 1'b0;
    endcase

    for (int unsigned n = 0; n < NUM_PORTS; n++) begin
      we[n] = !flush[n] &&
              ((state == DECODE && bus.pkt_valid && hdr_ok && hdr_empty && hdr_addr == 2'(n)) ||
               (state == LOAD && !cur_full && addr_q == 2'(n)));
    end
  end

  assign bus.busy     = busy;
  assign bus.err      = err_q;
  assign bus.bad_addr = bad_addr_q;
  assign bus.vld_out  = ~empty;
  assign bus.data_out = dout_flat;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= DECODE;
      addr_q     <= '0;
      xor_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      bad_addr_q <= 1'b0;
    end else begin
      bad_addr_q <= 1'b0;
      case (state)
        DECODE: begin
          if (bus.pkt_valid) begin
            if (!hdr_ok) begin
              state      <= DROP;
              bad_addr_q <= 1'b1;
            end else if (hdr_empty) begin
              state  <= LOAD;
              addr_q <= hdr_addr;
              err_q  <= 1'b0;
              xor_q  <= bus.data_in;
              len_q  <= bus.data_in[DATA_WIDTH-1:2];
              cnt_q  <= '0;
            end
          end
        end
        LOAD: begin
          if (cur_flush) begin
            state <= DROP;
          end else if (!cur_full) begin
            xor_q <= xor_q ^ bus.data_in;
            if (bus.pkt_valid) begin
              if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          // Parity byte is folded into xor_q, so a good packet leaves it zero.
          err_q <= (xor_q != '0) || (cnt_q != {1'b0, len_q});
          state <= DECODE;
        end
        default: begin
          if (!bus.pkt_valid) state <= DECODE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned n = 0; n < NUM_PORTS; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        tmr[n]    <= '0;
        dout[n]   <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NUM_PORTS; n++) begin
        if (flush[n]) begin
          wr_ptr[n] <= '0;
          rd_ptr[n] <= '0;
        end else begin
          if (we[n]) wr_ptr[n] <= wr_ptr[n] + 1'b1;
          if (re[n]) rd_ptr[n] <= rd_ptr[n] + 1'b1;
        end
        if (re[n]) dout[n] <= mem[n][rd_ptr[n][AW-1:0]];
        if (!empty[n] && !bus.read_enb[n]) tmr[n] <= flush[n] ? '0 : tmr[n] + 1'b1;
        else                               tmr[n] <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned n = 0; n < NUM_PORTS; n++) begin
      if (we[n]) mem[n][wr_ptr[n][AW-1:0]] <= bus.data_in;
    end
  end
endmodule

// File: doc/router_1xn.md
# router_1xn

Parametrised single-input, N-output packet router: the next generation of the 1x3 router. It receives framed packets on one byte-wide input, decodes the destination from the header, and buffers each packet in a per-port FIFO drained by an independent reader. It adds:
- configurable port count, data width, FIFO depth and soft-reset timeout;
- length checking alongside parity checking;
- discard of packets with an invalid address or a destination flushed mid-packet.

The FSM, FIFOs and timeout timers are implemented in one module.

## Interface
- NUM_PORTS, 3, number of output ports, legal range 2..4.
- DATA_WIDTH, 8, byte width, minimum 4.
- FIFO_DEPTH, 16, entries per port FIFO, power of 2, minimum 2.
- TIMEOUT, 30, consecutive unread cycles before a port is flushed, minimum 1.

- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pkt_valid  in  1  high while the source drives header or payload bytes.
- data_in  in  DATA_WIDTH  packet byte.
- busy  out  1  byte on data_in is not consumed this cycle; source must hold it.
- err  out  1  parity or length error on the last checked packet.
- bad_addr  out  1  one-cycle pulse: header addressed a nonexistent port.
- read_enb  in  NUM_PORTS  per-port read request.
- vld_out  out  NUM_PORTS  per-port FIFO non-empty.
- data_out  out  NUM_PORTS*DATA_WIDTH  packed per-port read data; port n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Packet format:
  - header: address in data_in[1:0], payload length L in data_in[DATA_WIDTH-1:2];
  - payload: L bytes with pkt_valid=1;
  - parity: one byte presented with pkt_valid=0, equal to the XOR of the header and all payload bytes.
- Consume rule:
  - a byte is consumed in any cycle with busy=0 while a packet is in progress, or with pkt_valid=1 in DECODE;
  - a consumed byte written to a FIFO is written at that clock edge.
- DECODE (reset state), entered when pkt_valid=1:
  - addr >= NUM_PORTS: header consumed, go to DROP, pulse bad_addr.
  - Valid addr and FIFO[addr] empty: header written, go to LOAD, clear err, latch addr, start parity/length accumulation.
  - Valid addr and FIFO[addr] non-empty: busy=1, stay in DECODE. This busy is combinational from pkt_valid, data_in and empty.
- LOAD:
  - busy = full[addr], combinational; while busy, no write.
  - A consumed byte with pkt_valid=1 is payload: write it, update the XOR, increment the payload counter. The counter is DATA_WIDTH-1 bits and saturates at all-ones.
  - A consumed byte with pkt_valid=0 is parity: write it, go to CHECK.
- CHECK: one cycle, busy=1. err is set if parity mismatches or payload count != L; go to DECODE.
- DROP:
  - busy=0; bytes are consumed and discarded.
  - The first consumed byte with pkt_valid=0 returns the FSM to DECODE; err is unchanged.
- Soft reset, per port:
  - The timer counts cycles with vld_out=1 and read_enb=0, and clears otherwise.
  - When it reaches TIMEOUT, the FIFO is flushed (empty) at that edge and the timer clears.
  - If the FSM is in LOAD to that port, it moves to DROP at the same edge, and any write in that cycle is discarded (flush wins).
- Read:
  - read_enb[n] with vld_out[n]=1 pops one entry into data_out[n], registered.
  - read_enb with an empty FIFO is ignored and data_out holds.
  - Simultaneous read and write on the same FIFO are both performed.
  - A write is blocked by full even when a read occurs in the same cycle.
- Zero-length packets (L=0) are legal: header, then parity.

## Timing
- Reset values: busy=0, err=0, bad_addr=0, vld_out=0, data_out=0, all FIFOs empty, timers 0, state DECODE.
- Header consumed in cycle T: vld_out[addr]=1 from T+1.
- read_enb sampled at edge R: popped byte on data_out from R+1 until the next pop.
- Parity consumed in cycle P:
  - CHECK occupies P+1 with busy=1;
  - err is valid from P+2;
  - the next header can be consumed at P+2.
- bad_addr is high exactly one cycle, the cycle after the bad header is consumed.
- Timeout: after TIMEOUT consecutive unread cycles, vld_out[n] falls on the following cycle.
- resetn low mid-packet returns everything to reset values immediately; the source must restart from a header.

## Test plan
- Reset: assert resetn=0 mid-traffic -> all outputs 0 immediately, and FSM in DECODE after release.
- Good packet (defaults):
  - stimulus: header 8'h0D (addr 1, L=3), payload 11/22/33, parity 8'h0D;
  - required: vld_out[1] rises the cycle after the header, err=0;
  - five reads return 0D, 11, 22, 33, 0D, after which vld_out[1]=0.
- Bad parity: same packet with parity 8'h00 -> err=1 at P+2. A header with length 5 and 4 payload bytes (correct parity) -> err=1. Next header consumed -> err=0.
- Backpressure: L=20 to port 0 with no reads -> busy=1 after the 16th write, and no data is lost. A single read -> busy drops one cycle and exactly one byte is accepted.
- Timeout: with a packet loading to port 2 and 30 cycles without read_enb[2] -> vld_out[2]=0. The remaining bytes are consumed with busy=0 and discarded, err stays 0, and the next packet to port 2 delivers normally.
- Bad address (NUM_PORTS=3): header 8'h07 -> one-cycle bad_addr pulse, no vld_out asserted. The payload is consumed and dropped, then DECODE.
